// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// The masked compare works on a fixed 32-bit container, so MAX_LEN must not exceed 32.
package seq_det_pkg;

   typedef enum logic {
      UNCFG = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int MAX_SUPPORTED_LEN = 32;

   // Width needed to hold a length value in the range 0..max_len.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Compare only the low 'len' bits of hist and pat; bit 0 is the newest serial bit.
   function automatic logic masked_eq(input logic [MAX_SUPPORTED_LEN-1:0] hist,
                                      input logic [MAX_SUPPORTED_LEN-1:0] pat,
                                      input logic [5:0]                   len);
      logic eq;
      eq = 1'b1;
      for (int i = 0; i < MAX_SUPPORTED_LEN; i++) begin
         if ((i < int'(len)) && (hist[i] != pat[i])) begin
            eq = 1'b0;
         end
      end
      return eq;
   endfunction

endpackage

// File: rtl/seq_det_matcher.sv
// Combinational compare of the candidate history against the programmed pattern,
// restricted to the programmed length.
module seq_det_matcher
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic [MAX_LEN-1:0] hist,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               match
);

   logic [MAX_SUPPORTED_LEN-1:0] hist_ext;
   logic [MAX_SUPPORTED_LEN-1:0] pat_ext;
   logic [5:0]                   len_ext;

   assign hist_ext = MAX_SUPPORTED_LEN'(hist);
   assign pat_ext  = MAX_SUPPORTED_LEN'(pattern);
   assign len_ext  = 6'(len);

   assign match = masked_eq(hist_ext, pat_ext, len_ext);

endmodule

// File: rtl/detect_programmable_sequence_using_fsm.sv
// Run-time programmable serial bit-sequence detector with valid qualifier,
// config-error flag, overlap control and a saturating match counter.
module detect_programmable_sequence_using_fsm
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_load,
   input  logic [MAX_LEN-1:0]                cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]      cfg_len,
   input  logic                              cfg_overlap,
   input  logic                              cnt_clear,
   input  logic                              in_valid,
   input  logic                              a,
   output logic                              detected,
   output logic [CNT_W-1:0]                  match_count,
   output logic                              cfg_err
);

   localparam int LEN_W = len_width(MAX_LEN);

   state_e               state_q,       state_d;
   logic [MAX_LEN-1:0]   pat_q,         pat_d;
   logic [LEN_W-1:0]     len_q,         len_d;
   logic                 overlap_q,     overlap_d;
   logic [MAX_LEN-1:0]   hist_q,        hist_d;
   logic [LEN_W-1:0]     hist_cnt_q,    hist_cnt_d;
   logic                 detected_q,    detected_d;
   logic [CNT_W-1:0]     match_count_q, match_count_d;
   logic                 cfg_err_q,     cfg_err_d;

   logic [MAX_LEN-1:0]   hist_shift;
   logic [LEN_W:0]       hist_cnt_inc;
   logic                 seen_enough;
   logic                 cmp_match;
   logic                 cfg_ok;

   assign hist_shift   = {hist_q[MAX_LEN-2:0], a};
   assign hist_cnt_inc = {1'b0, hist_cnt_q} + 1'b1;
   assign seen_enough  = hist_cnt_inc >= {1'b0, len_q};
   assign cfg_ok       = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(MAX_LEN));

   // Compare against the history as it will look after this bit is shifted in.
   seq_det_matcher #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_matcher (
      .hist    (hist_shift),
      .pattern (pat_q),
      .len     (len_q),
      .match   (cmp_match)
   );

   always_comb begin
      state_d       = state_q;
      pat_d         = pat_q;
      len_d         = len_q;
      overlap_d     = overlap_q;
      hist_d        = hist_q;
      hist_cnt_d    = hist_cnt_q;
      detected_d    = 1'b0;
      cfg_err_d     = cfg_err_q;
      match_count_d = cnt_clear ? '0 : match_count_q;

      if (cfg_load) begin
         pat_d      = cfg_pattern;
         len_d      = cfg_len;
         overlap_d  = cfg_overlap;
         hist_d     = '0;
         hist_cnt_d = '0;
         cfg_err_d  = !cfg_ok;
         state_d    = cfg_ok ? RUN : UNCFG;
      end else if ((state_q == RUN) && in_valid) begin
         hist_d     = hist_shift;
         hist_cnt_d = (hist_cnt_inc >= (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                           : hist_cnt_inc[LEN_W-1:0];
         if (seen_enough && cmp_match) begin
            detected_d = 1'b1;
            // Counting happens after any same-cycle clear, so clear+match yields 1.
            if (match_count_d != '1) begin
               match_count_d = match_count_d + 1'b1;
            end
            if (!overlap_q) begin
               hist_cnt_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= UNCFG;
         pat_q         <= '0;
         len_q         <= '0;
         overlap_q     <= 1'b0;
         hist_q        <= '0;
         hist_cnt_q    <= '0;
         detected_q    <= 1'b0;
         match_count_q <= '0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pat_q         <= pat_d;
         len_q         <= len_d;
         overlap_q     <= overlap_d;
         hist_q        <= hist_d;
         hist_cnt_q    <= hist_cnt_d;
         detected_q    <= detected_d;
         match_count_q <= match_count_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign detected    = detected_q;
   assign match_count = match_count_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_detect_programmable_sequence_using_fsm.sv
// Directed bench for the programmable sequence detector; a second instance with a
// 2-bit counter shares all inputs and is used for saturation checks.
module tb_detect_programmable_sequence_using_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       cnt_clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       a = 1'b0;
   logic       detected;
   logic [7:0] match_count;
   logic       cfg_err;
   logic       detected2;
   logic [1:0] match_count2;
   logic       cfg_err2;

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] stream = 24'b0011_0101_1001_1001_1010_1000;

   always #5 clk = ~clk;

   detect_programmable_sequence_using_fsm #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
      .in_valid(in_valid), .a(a), .detected(detected), .match_count(match_count),
      .cfg_err(cfg_err)
   );

   detect_programmable_sequence_using_fsm #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
      .in_valid(in_valid), .a(a), .detected(detected2), .match_count(match_count2),
      .cfg_err(cfg_err2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", tag, got, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // in_valid/a are driven during the load to confirm cfg_load has priority.
   task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                         input logic exp_err);
      cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      in_valid = 1'b1; a = 1'b1;
      tick();
      cfg_load = 1'b0; in_valid = 1'b0;
      check_eq("cfg_err", 32'(cfg_err), 32'(exp_err));
      check_eq("cfg_no_det", 32'(detected), 32'd0);
   endtask

   task automatic send(input logic b, input logic exp_det, input string tag);
      in_valid = 1'b1; a = b;
      tick();
      in_valid = 1'b0;
      check_eq(tag, 32'(detected), 32'(exp_det));
   endtask

   task automatic check_counts(input logic [7:0] exp8, input logic [1:0] exp2);
      check_eq("count", 32'(match_count), 32'(exp8));
      check_eq("count_sat", 32'(match_count2), 32'(exp2));
   endtask

   task automatic clear_cnt();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      check_counts(8'd0, 2'd0);
   endtask

   // Slot s (1-based, left to right) lives at bit 24-s of both stream and mask.
   task automatic run_stream(input logic [23:0] exp_mask, input string tag);
      for (int s = 1; s <= 24; s++) begin
         send(stream[24-s], exp_mask[24-s], tag);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_det", 32'(detected), 32'd0);
      check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
      check_counts(8'd0, 2'd0);
      tick(); tick();
      rst_n = 1'b1;

      // Unconfigured: inputs ignored
      send(1'b1, 1'b0, "uncfg_det");
      send(1'b1, 1'b0, "uncfg_det");

      // len=4 1010 overlapping: slots 7, 20, 22
      do_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0);
      run_stream(24'b0000_0010_0000_0000_0001_0100, "s1010_det");
      check_counts(8'd3, 2'd3);
      clear_cnt();

      // len=6 110011 overlapping: slots 13, 17
      do_cfg(8'b0011_0011, 4'd6, 1'b1, 1'b0);
      run_stream(24'b0000_0000_0000_1000_1000_0000, "s110011_ov_det");
      check_counts(8'd2, 2'd2);
      clear_cnt();

      // Same, non-overlapping: slot 13 only
      do_cfg(8'b0011_0011, 4'd6, 1'b0, 1'b0);
      run_stream(24'b0000_0000_0000_1000_0000_0000, "s110011_nov_det");
      check_counts(8'd1, 2'd1);
      clear_cnt();

      // in_valid gaps hold history
      do_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0);
      send(1'b1, 1'b0, "gap_det");
      send(1'b0, 1'b0, "gap_det");
      for (int i = 0; i < 3; i++) begin
         a = 1'b1;
         tick();
         check_eq("gap_idle_det", 32'(detected), 32'd0);
      end
      send(1'b1, 1'b0, "gap_det");
      send(1'b0, 1'b1, "gap_final_det");
      tick();
      check_eq("pulse_one_cycle", 32'(detected), 32'd0);
      check_counts(8'd1, 2'd1);

      // len=MAX_LEN compares the whole history
      do_cfg(8'b1100_1010, 4'd8, 1'b1, 1'b0);
      send(1'b1, 1'b0, "len8_det"); send(1'b1, 1'b0, "len8_det");
      send(1'b0, 1'b0, "len8_det"); send(1'b0, 1'b0, "len8_det");
      send(1'b1, 1'b0, "len8_det"); send(1'b0, 1'b0, "len8_det");
      send(1'b1, 1'b0, "len8_det"); send(1'b0, 1'b1, "len8_final_det");
      check_counts(8'd2, 2'd2);

      // Illegal lengths drop back to UNCFG
      do_cfg(8'hFF, 4'd9, 1'b1, 1'b1);
      do_cfg(8'hFF, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0, "illegal_det");
      check_counts(8'd2, 2'd2);

      // len=1 pattern 1: every 1 matches; 2-bit counter saturates
      do_cfg(8'h01, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(1'b1, 1'b1, "len1_det");
      send(1'b0, 1'b0, "len1_zero_det");
      check_counts(8'd6, 2'd3);

      // Clear coincident with a match yields 1
      cnt_clear = 1'b1;
      send(1'b1, 1'b1, "clr_match_det");
      cnt_clear = 1'b0;
      check_counts(8'd1, 2'd1);

      // Reset mid-stream while detected is high
      do_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0);
      send(1'b1, 1'b0, "pre_rst_det"); send(1'b0, 1'b0, "pre_rst_det");
      send(1'b1, 1'b0, "pre_rst_det"); send(1'b0, 1'b1, "pre_rst_final_det");
      rst_n = 1'b0;
      #1;
      check_eq("midrst_det", 32'(detected), 32'd0);
      check_eq("midrst_cfg_err", 32'(cfg_err), 32'd0);
      check_counts(8'd0, 2'd0);
      tick();
      rst_n = 1'b1;
      send(1'b1, 1'b0, "post_rst_det"); send(1'b0, 1'b0, "post_rst_det");
      send(1'b1, 1'b0, "post_rst_det"); send(1'b0, 1'b0, "post_rst_det");
      check_counts(8'd0, 2'd0);
      do_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0);
      send(1'b1, 1'b0, "recfg_det"); send(1'b0, 1'b0, "recfg_det");
      send(1'b1, 1'b0, "recfg_det"); send(1'b0, 1'b1, "recfg_final_det");
      check_counts(8'd1, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
